// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, selectable CPOL/CPHA/bit order, clock divider and slave select.
// Each word latches its own configuration so input changes never disturb a word in flight.
module spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 2,
  parameter int DIV_W      = 16,
  localparam int SS_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              burst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              rx_overrun,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  input  logic              miso
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int EC_W = $clog2(2 * DATA_W);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [EC_W-1:0]     r_edge_cnt;
  logic                r_sck, r_mosi, r_overrun;
  logic [NUM_SS-1:0]   r_ss_n;
  logic                r_cpha, r_lsb, r_burst;
  logic [DIV_W-1:0]    r_clk_div;
  logic [SS_W-1:0]     r_ss_sel;
  logic [DATA_W-1:0]   r_tx_sh, r_rx_sh;

  logic [DATA_W-1:0]   r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_tx_wr, r_tx_rd;
  logic [CW-1:0]       r_tx_cnt;
  logic [DATA_W-1:0]   r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_rx_wr, r_rx_rd;
  logic [CW-1:0]       r_rx_cnt;

  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic w_rx_full, w_rx_push, w_rx_pop;
  logic w_tick, w_idle_done, w_last_edge, w_burst_go, w_start, w_sample, w_drive;
  logic w_first_bit, w_mosi_next;
  logic [DATA_W-1:0] w_tx_head, w_rx_next, w_rx_word, w_tx_shifted;

  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (sel == SS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  // ---------------- FIFO status and handshakes ----------------
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_push  = tx_valid && !w_tx_full;
  assign w_tx_pop   = w_start;
  assign tx_ready   = !w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rd];

  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign rx_valid   = (r_rx_cnt != '0);
  assign w_rx_pop   = rx_valid && rx_ready;
  assign w_rx_push  = w_last_edge && !w_rx_full;
  assign rx_data    = rx_valid ? r_rx_mem[r_rx_rd] : '0;

  // NOTE: FIFO storage has no reset; the counters alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= w_rx_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr <= '0; r_tx_rd <= '0; r_tx_cnt <= '0;
      r_rx_wr <= '0; r_rx_rd <= '0; r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // ---------------- Shift engine ----------------
  assign w_tick      = (r_div_cnt == r_clk_div);
  assign w_idle_done = (r_div_cnt >= clk_div);
  assign w_last_edge = (r_state == ST_SHIFT) && w_tick && (r_edge_cnt == LAST_EDGE);
  assign w_burst_go  = w_last_edge && r_burst && !w_tx_empty && (ss_sel == r_ss_sel);
  assign w_start     = ((r_state == ST_IDLE) && !w_tx_empty && w_idle_done) || w_burst_go;

  // Even edge indices are leading edges; CPHA picks which parity samples.
  assign w_sample  = (r_edge_cnt[0] == r_cpha);
  assign w_drive   = !w_sample && !(r_cpha && r_edge_cnt == '0) && (r_edge_cnt != LAST_EDGE);
  assign w_rx_next = r_lsb ? {miso, r_rx_sh[DATA_W-1:1]} : {r_rx_sh[DATA_W-2:0], miso};
  assign w_rx_word = w_sample ? w_rx_next : r_rx_sh;
  assign w_tx_shifted = r_lsb ? {1'b0, r_tx_sh[DATA_W-1:1]} : {r_tx_sh[DATA_W-2:0], 1'b0};
  assign w_mosi_next  = r_lsb ? r_tx_sh[1] : r_tx_sh[DATA_W-2];
  assign w_first_bit  = lsb_first ? w_tx_head[0] : w_tx_head[DATA_W-1];

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= '1;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_burst    <= 1'b0;
      r_clk_div  <= '0;
      r_ss_sel   <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= w_last_edge && w_rx_full;
      if (w_start) begin
        r_state    <= ST_SETUP;
        r_div_cnt  <= '0;
        r_edge_cnt <= '0;
        r_cpha     <= cpha;
        r_lsb      <= lsb_first;
        r_burst    <= burst;
        r_clk_div  <= clk_div;
        r_ss_sel   <= ss_sel;
        r_sck      <= cpol;
        r_ss_n     <= ss_decode(ss_sel);
        r_tx_sh    <= w_tx_head;
        r_mosi     <= w_first_bit;
        r_rx_sh    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_idle_done) r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
          ST_SETUP: begin
            if (w_tick) begin
              r_div_cnt <= '0;
              r_state   <= ST_SHIFT;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
          ST_SHIFT: begin
            if (w_tick) begin
              r_div_cnt  <= '0;
              r_sck      <= ~r_sck;
              r_edge_cnt <= r_edge_cnt + EC_W'(1);
              if (w_sample) r_rx_sh <= w_rx_next;
              if (w_drive) begin
                r_tx_sh <= w_tx_shifted;
                r_mosi  <= w_mosi_next;
              end
              if (w_last_edge) r_state <= ST_HOLD;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
          ST_HOLD: begin
            if (w_tick) begin
              r_div_cnt <= '0;
              r_ss_n    <= '1;
              r_state   <= ST_IDLE;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign rx_overrun = r_overrun;
  assign sck        = r_sck;
  assign mosi       = r_mosi;
  assign ss_n       = r_ss_n;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: loopback and a mode-aware SPI slave on ss_n[0],
// with a negedge monitor measuring SCK timing, SS activity and FIFO flags.
module tb_spi_master_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, burst = 1'b0;
  logic [15:0] clk_div = 16'd1;
  logic [0:0]  ss_sel = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready = 1'b0;
  logic        busy, rx_overrun, sck, mosi, miso;
  logic [1:0]  ss_n;

  logic        loopback = 1'b1;
  logic        sl_miso = 1'b0;
  logic [7:0]  slv_word = 8'h81;
  logic [7:0]  sl_rx = 8'h00;
  int          sl_idx = 0, sl_edges = 0;

  int n_checks = 0, n_fail = 0;

  logic mon_clr = 1'b0;
  logic sck_q = 1'b0, busy_q = 1'b0, ss0_q = 1'b1;
  int   cyc = 0, rise_cnt = 0, last_rise = -1, per_min = 1000, per_max = 0;
  int   last_tog = -1, hp_min = 1000, hp_max = 0, ss_bad = 0, ss0_rise = 0;
  int   ovr_cnt = 0, word_start = 0, word_last = 0;
  logic saw_full = 1'b0;
  logic [7:0] mosi_cap = 8'h00;

  assign miso = loopback ? mosi : sl_miso;

  spi_master_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_SS(2), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .clk_div(clk_div), .ss_sel(ss_sel), .burst(burst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .rx_overrun(rx_overrun), .sck(sck), .mosi(mosi), .ss_n(ss_n), .miso(miso)
  );

  always #5 clk = ~clk;

  // Monitor and slave model, both observing the bus half a clock after each edge.
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    sck_q  <= sck;
    busy_q <= busy;
    ss0_q  <= ss_n[0];
    if (mon_clr) begin
      rise_cnt <= 0; last_rise <= -1; per_min <= 1000; per_max <= 0;
      last_tog <= -1; hp_min <= 1000; hp_max <= 0; ss_bad <= 0; ss0_rise <= 0;
      ovr_cnt <= 0; saw_full <= 1'b0; word_start <= 0; word_last <= 0; mosi_cap <= 8'h00;
    end else begin
      if (sck != sck_q) begin
        if (last_tog >= 0) begin
          if (cyc - last_tog < hp_min) hp_min <= cyc - last_tog;
          if (cyc - last_tog > hp_max) hp_max <= cyc - last_tog;
        end
        last_tog  <= cyc;
        word_last <= cyc;
        if (ss_n[0]) ss_bad <= ss_bad + 1;
        if (sck) begin
          rise_cnt <= rise_cnt + 1;
          mosi_cap <= {mosi_cap[6:0], mosi};
          if (last_rise >= 0) begin
            if (cyc - last_rise < per_min) per_min <= cyc - last_rise;
            if (cyc - last_rise > per_max) per_max <= cyc - last_rise;
          end
          last_rise <= cyc;
        end
      end
      if (busy && !busy_q) word_start <= cyc;
      if (ss_n[0] && !ss0_q) ss0_rise <= ss0_rise + 1;
      if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
      if (!tx_ready) saw_full <= 1'b1;
    end
    if (!ss_n[0] && ss0_q) begin
      sl_idx   <= 0;
      sl_edges <= 0;
      sl_miso  <= slv_word[0];
    end else if (!ss_n[0] && sck != sck_q) begin
      sl_edges <= sl_edges + 1;
      if ((sck_q == cpol) ^ cpha) begin
        sl_rx <= {mosi, sl_rx[7:1]};
      end else if (!(cpha && sl_edges == 0) && sl_idx < 7) begin
        sl_idx  <= sl_idx + 1;
        sl_miso <= slv_word[sl_idx + 1];
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 300) begin @(negedge clk); n++; end
    if (!tx_ready) begin
      $display("FAIL push_timeout data=%h tx_ready stayed low", d); n_fail++; n_checks++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_word(output logic [7:0] d);
    int n = 0;
    while (!rx_valid && n < 300) begin @(negedge clk); n++; end
    if (!rx_valid) begin
      $display("FAIL pop_timeout rx_valid stayed low"); n_fail++; n_checks++;
    end
    d = rx_data;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0, run = 0;
    while (run < 8 && n < 3000) begin
      @(negedge clk); n++;
      run = busy ? 0 : run + 1;
    end
    if (run < 8) begin
      $display("FAIL done_timeout busy still high after %0d cycles", n); n_fail++; n_checks++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if (tx_ready !== 1'b1)  begin $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); n_fail++; end n_checks++;
    if (rx_valid !== 1'b0)  begin $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); n_fail++; end n_checks++;
    if (busy !== 1'b0)      begin $display("FAIL rst_busy got=%b exp=0", busy); n_fail++; end n_checks++;
    if (rx_overrun !== 1'b0) begin $display("FAIL rst_overrun got=%b exp=0", rx_overrun); n_fail++; end n_checks++;
    if (sck !== 1'b0)       begin $display("FAIL rst_sck got=%b exp=0", sck); n_fail++; end n_checks++;
    if (mosi !== 1'b0)      begin $display("FAIL rst_mosi got=%b exp=0", mosi); n_fail++; end n_checks++;
    if (ss_n !== 2'b11)     begin $display("FAIL rst_ss_n got=%b exp=11", ss_n); n_fail++; end n_checks++;
    if (rx_data !== 8'h00)  begin $display("FAIL rst_rx_data got=%h exp=00", rx_data); n_fail++; end n_checks++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] d;
    cpol = 0; cpha = 0; lsb_first = 0; clk_div = 16'd1; burst = 0; ss_sel = 1'b0; loopback = 1;
    clear_mon();
    push_word(8'hA5);
    wait_done();
    pop_word(d);
    if (d !== 8'hA5)       begin $display("FAIL basic_rx got=%h exp=a5", d); n_fail++; end n_checks++;
    if (mosi_cap !== 8'hA5) begin $display("FAIL basic_mosi got=%h exp=a5", mosi_cap); n_fail++; end n_checks++;
    if (rise_cnt !== 8)    begin $display("FAIL basic_rises got=%0d exp=8", rise_cnt); n_fail++; end n_checks++;
    if (per_min !== 4 || per_max !== 4) begin
      $display("FAIL basic_period got=%0d..%0d exp=4", per_min, per_max); n_fail++; end n_checks++;
    if (ss_bad !== 0)      begin $display("FAIL basic_ss_held got=%0d edges with ss_n[0] high exp=0", ss_bad); n_fail++; end n_checks++;
    if (ss0_rise !== 1)    begin $display("FAIL basic_ss_release got=%0d exp=1", ss0_rise); n_fail++; end n_checks++;
    if (ss_n !== 2'b11)    begin $display("FAIL basic_ss_idle got=%b exp=11", ss_n); n_fail++; end n_checks++;
  endtask

  task automatic test_modes();
    logic [7:0] d;
    logic [1:0] m;
    for (int i = 0; i < 4; i++) begin
      m = 2'(i);
      cpol = m[1]; cpha = m[0]; lsb_first = 1; clk_div = 16'd1; burst = 0; loopback = 0;
      clear_mon();
      push_word(8'h3C);
      wait_done();
      pop_word(d);
      if (d !== 8'h81)     begin $display("FAIL mode%0d_rx got=%h exp=81", i, d); n_fail++; end n_checks++;
      if (sl_rx !== 8'h3C) begin $display("FAIL mode%0d_mosi got=%h exp=3c", i, sl_rx); n_fail++; end n_checks++;
      if (sck !== m[1])    begin $display("FAIL mode%0d_sck_idle got=%b exp=%b", i, sck, m[1]); n_fail++; end n_checks++;
    end
    loopback = 1; lsb_first = 0; cpha = 0;
  endtask

  task automatic test_burst(input logic b);
    logic [7:0] d;
    logic [7:0] w [3];
    w[0] = 8'h11; w[1] = 8'h96; w[2] = 8'hE7;
    cpol = 0; cpha = 0; lsb_first = 0; clk_div = 16'd0; burst = b; loopback = 1;
    clear_mon();
    for (int i = 0; i < 3; i++) push_word(w[i]);
    wait_done();
    if (ss0_rise !== (b ? 1 : 3)) begin
      $display("FAIL burst%0b_ss_release got=%0d exp=%0d", b, ss0_rise, b ? 1 : 3); n_fail++; end n_checks++;
    if (rise_cnt !== 24) begin $display("FAIL burst%0b_rises got=%0d exp=24", b, rise_cnt); n_fail++; end n_checks++;
    for (int i = 0; i < 3; i++) begin
      pop_word(d);
      if (d !== w[i]) begin $display("FAIL burst%0b_rx%0d got=%h exp=%h", b, i, d, w[i]); n_fail++; end n_checks++;
    end
    burst = 0;
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    cpol = 0; cpha = 0; clk_div = 16'd0; burst = 0; loopback = 1; rx_ready = 0;
    clear_mon();
    for (int i = 0; i < 6; i++) push_word(8'h40 + 8'(i));
    wait_done();
    if (saw_full !== 1'b1) begin $display("FAIL ovr_tx_full got=%b exp=1", saw_full); n_fail++; end n_checks++;
    if (ovr_cnt !== 2)     begin $display("FAIL ovr_pulses got=%0d exp=2", ovr_cnt); n_fail++; end n_checks++;
    for (int i = 0; i < 4; i++) begin
      pop_word(d);
      if (d !== 8'h40 + 8'(i)) begin $display("FAIL ovr_rx%0d got=%h exp=%h", i, d, 8'h40 + 8'(i)); n_fail++; end n_checks++;
    end
    if (rx_valid !== 1'b0) begin $display("FAIL ovr_rx_empty got=%b exp=0", rx_valid); n_fail++; end n_checks++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    cpol = 0; cpha = 0; clk_div = 16'd1; burst = 0; loopback = 1;
    clear_mon();
    push_word(8'h5A);
    push_word(8'h77);
    while (rise_cnt < 4 && n < 200) begin @(negedge clk); n++; end
    if (rise_cnt < 4) begin $display("FAIL midrst_wait got=%0d rises exp>=4", rise_cnt); n_fail++; n_checks++; end
    rst = 1'b1;
    @(negedge clk);
    if (ss_n !== 2'b11)    begin $display("FAIL midrst_ss_n got=%b exp=11", ss_n); n_fail++; end n_checks++;
    if (busy !== 1'b0)     begin $display("FAIL midrst_busy got=%b exp=0", busy); n_fail++; end n_checks++;
    if (rx_valid !== 1'b0) begin $display("FAIL midrst_rx_valid got=%b exp=0", rx_valid); n_fail++; end n_checks++;
    if (tx_ready !== 1'b1) begin $display("FAIL midrst_tx_ready got=%b exp=1", tx_ready); n_fail++; end n_checks++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    if (busy !== 1'b0)     begin $display("FAIL midrst_tx_flushed busy got=%b exp=0", busy); n_fail++; end n_checks++;
    if (rx_valid !== 1'b0) begin $display("FAIL midrst_rx_flushed got=%b exp=0", rx_valid); n_fail++; end n_checks++;
  endtask

  task automatic test_fast();
    logic [7:0] d;
    cpol = 0; cpha = 0; clk_div = 16'd0; burst = 0; loopback = 1;
    clear_mon();
    push_word(8'hC3);
    wait_done();
    pop_word(d);
    if (d !== 8'hC3) begin $display("FAIL fast_rx got=%h exp=c3", d); n_fail++; end n_checks++;
    if (hp_min !== 1 || hp_max !== 1) begin
      $display("FAIL fast_half_period got=%0d..%0d exp=1", hp_min, hp_max); n_fail++; end n_checks++;
    if (word_last - word_start !== 17) begin
      $display("FAIL fast_word_time got=%0d exp=17", word_last - word_start); n_fail++; end n_checks++;
    if (rise_cnt !== 8) begin $display("FAIL fast_rises got=%0d exp=8", rise_cnt); n_fail++; end n_checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_burst(1'b1);
    test_burst(1'b0);
    test_overrun();
    test_reset_mid();
    test_fast();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
